// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and parity-mode encodings,
// reused by the future transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an idle-high asynchronous input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: mid-bit sampling, optional parity, 1-2 stop bits,
// single-entry holding register with valid/ready handshake and overrun pulse.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_perr,
  output logic                 out_ferr,
  output logic                 overrun
);
  localparam int             CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  HALF    = CW'(CLK_DIV/2 - 1);
  localparam logic [CW-1:0]  FULL    = CW'(CLK_DIV - 1);
  localparam logic [2:0]     LAST_DB = 3'(DATA_BITS - 1);
  localparam logic [2:0]     LAST_SB = 3'(STOP_BITS - 1);
  localparam logic           ODD     = (PARITY_ODD == PAR_ODD);

  uart_state_t          state;
  logic                 rx_s, rx_prev;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_r, ferr_r, done;
  logic                 tick;

  assign tick = (cnt == '0);

  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_prev   <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_perr  <= 1'b0;
      out_ferr  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      overrun <= 1'b0;
      done    <= 1'b0;

      // Completion lands one cycle after the last stop sample; a load wins
      // over a same-cycle transfer so valid stays high with the new word.
      if (done) begin
        if (!out_valid || out_ready) begin
          out_data  <= shreg;
          out_perr  <= perr_r;
          out_ferr  <= ferr_r;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Edge-triggered start: a line stuck low after a break never re-arms.
          if (rx_prev && !rx_s) begin
            state <= START;
            cnt   <= HALF;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= FULL;
              bit_cnt <= '0;
              perr_r  <= 1'b0;
              ferr_r  <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            cnt   <= FULL;
            if (bit_cnt == LAST_DB) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PARITY: begin
          if (tick) begin
            perr_r <= ^shreg ^ rx_s ^ ODD;
            cnt    <= FULL;
            state  <= STOP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            ferr_r <= ferr_r | ~rx_s;
            if (bit_cnt == LAST_SB) begin
              bit_cnt <= '0;
              cnt     <= '0;
              done    <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              cnt     <= FULL;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench: four receiver configurations driven with directed and random frames,
// scored against an expected-frame queue built from the frame contents.
module tb_uart_rx_frame;
  localparam int CD = 8;
  localparam logic [3:0][3:0] DBP = {4'd7, 4'd5, 4'd8, 4'd8};
  localparam logic [3:0]      PEP = 4'b1010;
  localparam logic [3:0]      POP = 4'b1000;
  localparam logic [3:0][1:0] SBP = {2'd2, 2'd2, 2'd1, 2'd1};

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] rx, rdy, ov, pe, fe, ovf;
  logic [3:0][7:0] od;

  int n_chk = 0, n_fail = 0;
  logic [9:0] exp_q [4][$];
  int ovr_cnt [4];
  int exp_ovr [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = int'(DBP[g]);
    logic [W-1:0] d;
    uart_rx_frame #(
      .CLK_DIV(CD), .DATA_BITS(W), .PARITY_EN(int'(PEP[g])),
      .PARITY_ODD(int'(POP[g])), .STOP_BITS(int'(SBP[g]))
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .rx(rx[g]), .out_data(d), .out_valid(ov[g]),
      .out_ready(rdy[g]), .out_perr(pe[g]), .out_ferr(fe[g]), .overrun(ovf[g])
    );
    assign od[g] = 8'(d);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted word must match the oldest expected frame.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst_n && ov[k] && rdy[k]) begin
        if (exp_q[k].size() == 0) begin
          chk($sformatf("d%0d_spurious", k), 1, 0);
        end else begin
          logic [9:0] e;
          e = exp_q[k].pop_front();
          chk($sformatf("d%0d_data", k), od[k], e[7:0]);
          chk($sformatf("d%0d_perr", k), pe[k], e[8]);
          chk($sformatf("d%0d_ferr", k), fe[k], e[9]);
        end
      end
      if (rst_n && ovf[k]) ovr_cnt[k]++;
    end
  end

  task automatic bitt(input int k, input logic b, input int cycles);
    rx[k] = b;
    repeat (cycles) @(negedge clk);
  endtask

  // Expected word follows the frame rules directly: masked data, parity
  // check over data+parity bit (+1 for odd), ferr if any stop bit is low.
  task automatic xfer(input int k, input logic [7:0] d, input logic pbit,
                      input logic [1:0] stops, input int hold_low, input int gap,
                      input bit expect_it);
    int db, sb;
    logic [7:0] dm;
    logic p, f;
    db = int'(DBP[k]);
    sb = int'(SBP[k]);
    dm = d & 8'((1 << db) - 1);
    p  = PEP[k] ? (^dm ^ pbit ^ POP[k]) : 1'b0;
    f  = (stops[0] == 1'b0) || (sb == 2 && stops[1] == 1'b0);
    if (expect_it) exp_q[k].push_back({f, p, dm});
    bitt(k, 1'b0, CD);
    for (int i = 0; i < db; i++) bitt(k, d[i], CD);
    if (PEP[k]) bitt(k, pbit, CD);
    for (int s = 0; s < sb; s++) bitt(k, stops[s], CD);
    if (hold_low > 0) bitt(k, 1'b0, hold_low);
    bitt(k, 1'b1, gap * CD + 2);
  endtask

  task automatic drain(input int k);
    int c = 0;
    while (exp_q[k].size() != 0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk($sformatf("d%0d_drain", k), exp_q[k].size(), 0);
  endtask

  initial begin
    int lat;
    rx = '1; rdy = '1; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", ov, 4'h0);
    chk("rst_data0", od[0], 8'h00);
    chk("rst_flags", {pe, fe, ovf}, 12'h000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5 with latency from the start edge
    lat = 0;
    fork
      xfer(0, 8'hA5, 1'b0, 2'b11, 0, 2, 1'b1);
      begin
        while (!ov[0] && lat < 200) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("lat_window", (lat >= 72 && lat <= 88), 1);
    drain(0);

    // Start glitch must be rejected
    bitt(0, 1'b0, 2);
    bitt(0, 1'b1, 100);
    chk("glitch_valid", ov[0], 1'b0);

    // Even parity, 0x07 with parity bit 0 -> parity error flagged
    xfer(1, 8'h07, 1'b0, 2'b11, 0, 2, 1'b1);
    drain(1);

    // Framing error then line held low, then a clean frame
    xfer(0, 8'h3C, 1'b0, 2'b10, 40, 2, 1'b1);
    xfer(0, 8'h55, 1'b0, 2'b11, 0, 2, 1'b1);
    drain(0);

    // Overrun: second frame dropped while first is held
    rdy[0] = 1'b0;
    xfer(0, 8'h11, 1'b0, 2'b11, 0, 1, 1'b1);
    xfer(0, 8'h22, 1'b0, 2'b11, 0, 1, 1'b0);
    exp_ovr[0]++;
    repeat (20) @(negedge clk);
    chk("ovr_hold_data", od[0], 8'h11);
    chk("ovr_hold_valid", ov[0], 1'b1);
    chk("ovr_pulses", ovr_cnt[0], exp_ovr[0]);
    rdy[0] = 1'b1;
    drain(0);
    @(negedge clk);
    chk("ovr_after_valid", ov[0], 1'b0);

    // 5-bit, 2 stop: held word, then reset in the 3rd data bit of 0x1F
    rdy[2] = 1'b0;
    xfer(2, 8'h0B, 1'b0, 2'b11, 0, 2, 1'b0);
    chk("held_valid2", ov[2], 1'b1);
    chk("held_data2", od[2], 8'h0B);
    bitt(2, 1'b0, CD);
    bitt(2, 1'b1, CD);
    bitt(2, 1'b1, CD);
    bitt(2, 1'b1, CD / 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid2", ov[2], 1'b0);
    chk("midrst_data2", od[2], 8'h00);
    chk("midrst_flags2", {pe[2], fe[2], ovf[2]}, 3'b000);
    rx[2] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rdy[2] = 1'b1;
    xfer(2, 8'h0A, 1'b0, 2'b11, 0, 2, 1'b1);
    drain(2);

    // Random frames on every configuration
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 8; n++) begin
        logic [7:0] d;
        logic pb;
        logic [1:0] st;
        d  = 8'($urandom);
        pb = 1'($urandom);
        st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
        xfer(k, d, pb, st, 0, $urandom_range(0, 2), 1'b1);
      end
      drain(k);
    end

    repeat (20) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d_left", k), exp_q[k].size(), 0);
      chk($sformatf("d%0d_ovr", k), ovr_cnt[k], exp_ovr[k]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter CLK_DIV, default 8: clocks per bit period; SHALL be >= 4 and even.
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-003 Parameter PARITY_EN, default 0: 1 means one parity bit follows the data bits.
REQ-004 Parameter PARITY_ODD, default 0: 0 means even parity, 1 means odd; ignored when PARITY_EN=0.
REQ-005 Parameter STOP_BITS, default 1: stop bits checked per frame, legal values 1 or 2.
REQ-006 clk  in  1  sole clock; all logic on the rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 rx  in  1  asynchronous serial line, idle high, LSB first.
REQ-009 out_data  out  DATA_BITS  received word, valid while out_valid=1.
REQ-010 out_valid  out  1  holding register full.
REQ-011 out_ready  in  1  consumer accept; a transfer occurs on a cycle where out_valid and out_ready are both 1.
REQ-012 out_perr  out  1  parity error for the held word; qualified by out_valid.
REQ-013 out_ferr  out  1  framing error (a stop bit sampled low) for the held word; qualified by out_valid.
REQ-014 overrun  out  1  one-cycle pulse when a completed frame is dropped.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer (reset value 1) before use; all references to rx below mean the synchronized signal.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE→START on a falling edge of rx (previous sample 1, current sample 0); the bit counter loads CLK_DIV/2-1.
REQ-018 START: when the counter reaches 0, sample rx. If 0 → DATA with the counter loaded to CLK_DIV-1; if 1 (glitch) → IDLE with no outputs changed.
REQ-019 Sampling rule for all later bits: sample at counter 0, then reload the counter to CLK_DIV-1, so every sample falls mid-bit.
REQ-020 DATA: shift the sample in at the MSB side (LSB-first reconstruction). After DATA_BITS samples → PARITY if PARITY_EN=1, otherwise → STOP.
REQ-021 PARITY: perr = XOR(data bits, parity sample, PARITY_ODD); then → STOP.
REQ-022 STOP: sample STOP_BITS bits. ferr = 1 if any stop sample is 0. After the last stop sample → IDLE the same cycle.
REQ-023 Completion, on the cycle after the last stop sample:
  - if out_valid=0, or out_valid=1 with out_ready=1: load out_data/out_perr/out_ferr and set out_valid=1;
  - otherwise: keep the held word and pulse overrun for 1 cycle.
REQ-024 out_valid clears on a transfer, unless the same cycle is a load (REQ-023), in which case out_valid stays 1 with the new word.
REQ-025 Frames with ferr or perr set SHALL still be delivered, with their flags.
REQ-026 After a framing error, IDLE SHALL NOT start a new frame until rx has been sampled 1 (a break is not a chain of frames). This follows from the edge rule in REQ-017.
REQ-027 Bit counter width: $clog2(CLK_DIV); data-bit counter width: 3 bits.
REQ-028 out_data, out_perr and out_ferr SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-029 While rst_n=0:
  - FSM in IDLE; all counters 0;
  - synchronizer and edge-detect flops 1;
  - out_data 0, out_valid 0, out_perr 0, out_ferr 0, overrun 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; no partial word is ever presented.

Structure
REQ-031 Package uart_pkg holds the FSM state enum and the parity-mode localparams; it is shared with the future transmitter.
REQ-032 One sub-module, sync_2ff: a 2-flop synchronizer with reset value 1. The rest stays flat.

Verification
REQ-033 CLK_DIV=8, 8N1, send 0xA5, out_ready=1 → out_valid pulses 1 cycle with out_data=0xA5, perr=0, ferr=0, about 76 clocks after the start edge.
REQ-034 rx low for 2 clocks, then high → FSM returns to IDLE, out_valid stays 0.
REQ-035 PARITY_EN=1, even parity, send 0x07 with parity bit 0 → out_data=0x07, out_perr=1, out_ferr=0.
REQ-036 Send 0x3C with stop bit 0 and rx held low 40 clocks → out_ferr=1; no second frame while rx is low; a following 0x55 is received correctly.
REQ-037 out_ready=0, send 0x11 then 0x22 → out_data stays 0x11, overrun pulses once; raising out_ready transfers 0x11 only.
REQ-038 DATA_BITS=5, STOP_BITS=2, send 0x1F; assert rst_n=0 during the 3rd data bit → all outputs 0 immediately; after release, a new 0x0A frame is received correctly.
